// File: rtl/uart_rx_led.sv
// uart_rx_led: 8N1 UART receiver that latches each good byte and shows its low nibble on the LEDs
module uart_rx_led #(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic [3:0] led,
   output logic       busy
);
   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] CPB  = 16'(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t      state_q, state_d;
   logic [1:0]  sync_q, sync_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic [3:0]  led_q, led_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        busy_q, busy_d;
   logic        rxs;

   assign sync_d    = {sync_q[0], rx};
   assign rxs       = sync_q[1];
   assign rx_data   = data_q;
   assign led       = led_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

   // Frame decoder: mid-bit sampling driven by a per-bit cycle counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      led_d   = led_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = START;
         end
         START: if (cnt_q == HALF - 16'd1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
         end
         DATA: if (cnt_q == CPB - 16'd1) begin
            cnt_d          = '0;
            shift_d[bit_q] = rxs;
            bit_d          = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
         end
         STOP: if (cnt_q == CPB - 16'd1) begin
            cnt_d = '0;
            if (rxs) begin
               data_d  = shift_q;
               led_d   = shift_q[3:0];
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = BREAK;
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   // State, synchronizer and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         led_q   <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         led_q   <= led_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end
endmodule

// File: doc/uart_rx_led.md
# uart_rx_led

Byte-oriented UART receiver that consumes the serial `tx` line produced by the LED-counter/UART-transmit stage and recovers each frame. The frame format is 8N1, LSB first. Each good byte is presented with a one-cycle valid strobe. Its low nibble is latched onto a 4-bit LED bus, so a loopback board or testbench can confirm that the counter value it sees matches the transmitted one. Bad frames are flagged and discarded.

## Interface
- `CLKS_PER_BIT`, default 1042: clock cycles per bit period (10 MHz / 9600 baud). Minimum legal value 8.
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately; release is sampled on `clk`.
- `rx` in 1: serial input. Idle level is high. Asynchronous to `clk`.
- `rx_data` out 8: last correctly received byte.
- `rx_valid` out 1: one-cycle strobe when `rx_data` is updated.
- `frame_err` out 1: one-cycle strobe when the stop bit samples low.
- `led` out 4: `rx_data[3:0]`, updated only on good frames.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rxs`.
- Define `HALF = CLKS_PER_BIT/2`, using integer floor. The bit counter is 16 bits wide. The data bit index is 3 bits wide.
- The FSM has five states: IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `rxs` = 0, go to START with the counter cleared.
  - **START:** count to `HALF-1`, then sample `rxs`.
    - Sample 0: go to DATA.
    - Sample 1: the low pulse was a glitch. Return to IDLE with no output.
  - **DATA:** every `CLKS_PER_BIT` cycles, sample `rxs` into `shift[bit_idx]`, starting at `bit_idx` = 0 (LSB first). After bit 7 is sampled, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` cycles, sample `rxs`.
    - Sample 1: load `rx_data` and `led` from `shift`, pulse `rx_valid`, go to IDLE.
    - Sample 0: pulse `frame_err`, leave `rx_data` and `led` unchanged, go to BREAK.
  - **BREAK:** wait until `rxs` = 1, then go to IDLE. This prevents a held-low line from being decoded as a stream of 0x00 bytes.
- `rx_valid` and `frame_err` are never high in the same cycle. Each is high for exactly one cycle per frame.
- A new start bit is accepted the cycle after a return to IDLE, so back-to-back frames with a single stop bit are received without loss.
- Reset values:
  - `rx_data` = 0x00, `led` = 0x0.
  - `rx_valid` = 0, `frame_err` = 0, `busy` = 0.
  - State = IDLE, synchronizer = 11.
- Reset asserted mid-frame aborts the frame with no strobe. After release, the receiver waits in IDLE for the next falling edge. A partially observed frame may be misread only if `rx` is already low at release; this case is accepted and is not checked.
- `busy` is a registered decode of state: high in START, DATA, STOP and BREAK.

## Timing
- Let T0 be the first `clk` edge at which the synchronizer output `rxs` shows 0 while in IDLE. That is 2–3 edges after the `rx` fall.
- Sample points occur at T0 + `HALF` + k·`CLKS_PER_BIT`:
  - k = 0: start bit.
  - k = 1..8: data bits 0..7.
  - k = 9: stop bit.
- `rx_valid` or `frame_err` is high during the cycle immediately after the stop-bit sample edge. `rx_data` and `led` are valid from that same cycle.
- Total latency from the `rx` fall to `rx_valid` is 2 + `HALF` + 9·`CLKS_PER_BIT` + 1 cycles, with ±1 allowed for synchronizer phase.
- The design tolerates ±3% baud mismatch, because samples are taken at mid-bit.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and drive `rx` at exactly 16 clocks per bit.
- **Good byte:** send 0xA5. Require one `rx_valid` pulse, `rx_data` = 0xA5, `led` = 4'h5, `frame_err` never high, and `busy` low again after the pulse.
- **Glitch rejection:** drive `rx` low for 4 cycles, then high. Require no `rx_valid` and no `frame_err`, `busy` high for at most `HALF` + 3 cycles, and `rx_data` unchanged.
- **Framing error:**
  - First send 0x3C good, then 0x81 with the stop bit driven 0, holding `rx` low for 40 more cycles.
  - Require one `frame_err` pulse, then `rx_data` = 0x3C and `led` = 4'hC still.
  - Require no further strobes until `rx` returns high.
  - A following good 0x5A must then yield `rx_data` = 0x5A.
- **Back-to-back:** send 0x00, 0xFF, 0x96 with single stop bits and no idle gap. Require exactly three `rx_valid` pulses, 160 cycles apart, with data 0x00, 0xFF, 0x96 and final `led` = 4'h6.
- **Reset mid-frame:** start sending 0xF0 and assert `reset` low after data bit 3.
  - Require all outputs to be 0 immediately and `busy` = 0.
  - Release `reset` with `rx` high, then send 0x12. Require a single `rx_valid` with `rx_data` = 0x12 and `led` = 4'h2.
- **Loopback:** connect `rx` to the upstream transmitter's `tx`. Require `led` to track the transmitter's 4-bit counter value one frame later, for 20 consecutive frames including the 4'hF→4'h0 wrap.
